// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - rv32i fetch front end: PC, I-cache read handshake, {pc,instr} FIFO to IF/ID
// Optional FETCH_PERF_EN adds perf_fetched/perf_stall/perf_flush counters.
module fetch_unit #(
  parameter int              XLEN        = 32,
  parameter int              QUEUE_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = 'h00000060
) (
  input  logic            clk,
  input  logic            rst,
  output logic            inst_read,
  output logic [XLEN-1:0] inst_addr,
  input  logic            inst_resp,
  input  logic [31:0]     inst_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flush
`endif
);

  localparam int            PW      = $clog2(QUEUE_DEPTH);
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] pend_pc;
  logic [XLEN-1:0] redirect_tgt;
  logic [XLEN-1:0] q_pc    [QUEUE_DEPTH];
  logic [31:0]     q_instr [QUEUE_DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic            has_space;

  // fetch_pc is left untouched while draining, so it doubles as the held request address
  assign inst_read = (state != S_IDLE);
  assign inst_addr = fetch_pc;
  assign id_valid  = (count != '0);
  assign id_pc     = id_valid ? q_pc[rptr] : '0;
  assign id_instr  = id_valid ? q_instr[rptr] : '0;

  always_comb begin
    push         = (state == S_REQ) && inst_resp && !redirect_valid;
    pop          = id_valid && id_ready;
    redirect_tgt = redirect_pc & ~XLEN'(3);
    count_next   = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    has_space    = (count_next < DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      pend_pc  <= '0;
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_tgt;
            state    <= S_REQ;
          end else if (has_space) begin
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (inst_resp) begin
            if (redirect_valid) begin
              fetch_pc <= redirect_tgt;
            end else begin
              fetch_pc <= fetch_pc + XLEN'(4);
              state    <= has_space ? S_REQ : S_IDLE;
            end
          end else if (redirect_valid) begin
            pend_pc <= redirect_tgt;
            state   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (inst_resp) begin
            fetch_pc <= redirect_valid ? redirect_tgt : pend_pc;
            state    <= S_REQ;
          end else if (redirect_valid) begin
            pend_pc <= redirect_tgt;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (push) begin
        q_pc[wptr]    <= fetch_pc;
        q_instr[wptr] <= inst_rdata;
      end
      if (redirect_valid) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) wptr <= wptr + PW'(1);
        if (pop)  rptr <= rptr + PW'(1);
      end
      count <= count_next;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
      perf_flush   <= '0;
    end else begin
      if (push)                   perf_fetched <= perf_fetched + 32'd1;
      if (inst_read && !inst_resp) perf_stall  <= perf_stall + 32'd1;
      if (redirect_valid)         perf_flush   <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a variable-latency I-cache model
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        inst_resp;
  logic [31:0] inst_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flush;
`endif

  fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .inst_read(inst_read),
    .inst_addr(inst_addr),
    .inst_resp(inst_resp),
    .inst_rdata(inst_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc(id_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall(perf_stall),
    .perf_flush(perf_flush)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [63:0] sb_q[$];
  int          resp_lat;
  int          wait_cnt;
  int          n_resp;
  logic [31:0] model_pc;
  logic        pend;
  logic [31:0] pend_t;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_0013;
  endfunction

  task automatic model_reset();
    sb_q.delete();
    wait_cnt = 0;
    n_resp   = 0;
    model_pc = 32'h60;
    pend     = 1'b0;
    pend_t   = 32'h0;
  endtask

  task automatic do_reset(input int n);
    rst            = 1'b0;
    inst_resp      = 1'b0;
    inst_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    repeat (n) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
  endtask

  // One clock cycle: time is 1 unit after a rising edge on entry and on exit.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
    logic        resp;
    logic [31:0] t;
    logic [63:0] exp;
    t    = tgt & ~32'h3;
    resp = (inst_read === 1'b1) && (wait_cnt >= resp_lat);
    if (inst_read === 1'b1) begin
      tests_run++;
      if (inst_addr !== model_pc) begin
        tests_failed++;
        $display("FAIL inst_addr: got %h expected %h", inst_addr, model_pc);
      end
    end
    tests_run++;
    if (id_valid !== (sb_q.size() != 0)) begin
      tests_failed++;
      $display("FAIL id_valid: got %b expected %b", id_valid, sb_q.size() != 0);
    end
    if (id_valid === 1'b1 && rdy && sb_q.size() != 0) begin
      exp = sb_q.pop_front();
      tests_run++;
      if ({id_pc, id_instr} !== exp) begin
        tests_failed++;
        $display("FAIL id_head: got pc %h instr %h expected pc %h instr %h",
                 id_pc, id_instr, exp[63:32], exp[31:0]);
      end
    end
    if (redir) sb_q.delete();
    if (resp) begin
      wait_cnt = 0;
      n_resp++;
      if (redir) begin
        pend     = 1'b0;
        model_pc = t;
      end else if (pend) begin
        pend     = 1'b0;
        model_pc = pend_t;
      end else begin
        sb_q.push_back({model_pc, imem(model_pc)});
        model_pc = model_pc + 32'd4;
      end
    end else begin
      if (inst_read === 1'b1) wait_cnt++;
      if (redir) begin
        if (inst_read === 1'b1) begin
          pend   = 1'b1;
          pend_t = t;
        end else begin
          model_pc = t;
        end
      end
    end
    inst_resp      = resp;
    inst_rdata     = resp ? imem(inst_addr) : 32'h0;
    redirect_valid = redir;
    redirect_pc    = tgt;
    id_ready       = rdy;
    @(posedge clk);
    #1;
    inst_resp      = 1'b0;
    redirect_valid = 1'b0;
  endtask

  task automatic wait_addr(input logic [31:0] a, input logic rdy);
    int n;
    n = 0;
    while (!(inst_read === 1'b1 && inst_addr === a) && n < 200) begin
      step(rdy, 1'b0, 32'h0);
      n++;
    end
    if (n >= 200) begin
      tests_run++;
      tests_failed++;
      $display("FAIL wait_addr: address %h never requested", a);
    end
  endtask

  task automatic test_reset();
    resp_lat = 0;
    id_ready = 1'b1;
    do_reset(2);
    tests_run += 4;
    if (inst_read !== 1'b0) begin tests_failed++; $display("FAIL reset_inst_read: got %b expected 0", inst_read); end
    if (id_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    if (id_instr !== 32'h0) begin tests_failed++; $display("FAIL reset_id_instr: got %h expected 0", id_instr); end
    if (id_pc !== 32'h0) begin tests_failed++; $display("FAIL reset_id_pc: got %h expected 0", id_pc); end
    step(1'b1, 1'b0, 32'h0);
    tests_run++;
    if (!(inst_read === 1'b1 && inst_addr === 32'h60)) begin
      tests_failed++;
      $display("FAIL first_req: got read %b addr %h expected read 1 addr 00000060", inst_read, inst_addr);
    end
  endtask

  task automatic test_stream();
    resp_lat = 0;
    do_reset(2);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 10; k++) begin
      tests_run++;
      if (!(id_valid === 1'b1 && id_pc === 32'h60 + 32'(4 * k) &&
            inst_read === 1'b1 && inst_addr === 32'h64 + 32'(4 * k))) begin
        tests_failed++;
        $display("FAIL stream_%0d: got valid %b pc %h read %b addr %h expected valid 1 pc %h read 1 addr %h",
                 k, id_valid, id_pc, inst_read, inst_addr, 32'h60 + 32'(4 * k), 32'h64 + 32'(4 * k));
      end
      step(1'b1, 1'b0, 32'h0);
    end
  endtask

  task automatic test_backpressure();
    int          reads;
    int          got;
    logic [31:0] pcs[5];
    resp_lat = 0;
    id_ready = 1'b0;
    do_reset(2);
    reads = 0;
    for (int k = 0; k < 10; k++) begin
      if (inst_read === 1'b1) reads++;
      step(1'b0, 1'b0, 32'h0);
    end
    tests_run += 2;
    if (reads != 4) begin tests_failed++; $display("FAIL bp_reads: got %0d expected 4", reads); end
    if (inst_read !== 1'b0) begin tests_failed++; $display("FAIL bp_idle: got read %b expected 0", inst_read); end
    got = 0;
    for (int k = 0; k < 12 && got < 5; k++) begin
      if (id_valid === 1'b1) begin
        pcs[got] = id_pc;
        got++;
      end
      step(1'b1, 1'b0, 32'h0);
      if (k == 0) begin
        tests_run++;
        if (!(inst_read === 1'b1 && inst_addr === 32'h70)) begin
          tests_failed++;
          $display("FAIL bp_resume: got read %b addr %h expected read 1 addr 00000070", inst_read, inst_addr);
        end
      end
    end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (i >= got || pcs[i] !== 32'h60 + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL bp_order_%0d: got %h expected %h", i, (i < got) ? pcs[i] : 32'hx, 32'h60 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_wait();
    int held;
    int n;
    resp_lat = 3;
    do_reset(2);
    wait_addr(32'h64, 1'b1);
    step(1'b1, 1'b1, 32'h200);
    held = 1;
    n = 0;
    while (!(inst_read === 1'b1 && inst_addr === 32'h200) && n < 20) begin
      if (inst_read === 1'b1 && inst_addr === 32'h64) held++;
      step(1'b1, 1'b0, 32'h0);
      n++;
    end
    tests_run++;
    if (held != 4) begin tests_failed++; $display("FAIL rw_hold: got %0d cycles at 64 expected 4", held); end
    n = 0;
    while (id_valid !== 1'b1 && n < 20) begin
      step(1'b1, 1'b0, 32'h0);
      n++;
    end
    tests_run++;
    if (id_pc !== 32'h200) begin tests_failed++; $display("FAIL rw_first_pc: got %h expected 00000200", id_pc); end
  endtask

  task automatic test_redirect_resp();
    resp_lat = 0;
    do_reset(2);
    wait_addr(32'h68, 1'b1);
    step(1'b1, 1'b1, 32'h203);
    tests_run++;
    if (!(id_valid === 1'b0 && inst_read === 1'b1 && inst_addr === 32'h200)) begin
      tests_failed++;
      $display("FAIL rr_flush: got valid %b read %b addr %h expected valid 0 read 1 addr 00000200",
               id_valid, inst_read, inst_addr);
    end
    repeat (4) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_reset_mid();
    resp_lat = 1;
    do_reset(2);
    wait_addr(32'h80, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (!(inst_read === 1'b0 && id_valid === 1'b0)) begin
      tests_failed++;
      $display("FAIL rm_reset: got read %b valid %b expected 0 0", inst_read, id_valid);
    end
    model_reset();
    rst = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    tests_run++;
    if (!(inst_read === 1'b1 && inst_addr === 32'h60)) begin
      tests_failed++;
      $display("FAIL rm_restart: got read %b addr %h expected read 1 addr 00000060", inst_read, inst_addr);
    end
    repeat (4) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic test_wrap();
    int          got;
    logic [31:0] pcs[3];
    resp_lat = 0;
    id_ready = 1'b0;
    do_reset(2);
    repeat (8) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    tests_run++;
    if (!(id_valid === 1'b0 && inst_read === 1'b1 && inst_addr === 32'hFFFF_FFFC)) begin
      tests_failed++;
      $display("FAIL wrap_idle_redirect: got valid %b read %b addr %h expected valid 0 read 1 addr fffffffc",
               id_valid, inst_read, inst_addr);
    end
    got = 0;
    for (int k = 0; k < 8 && got < 3; k++) begin
      if (id_valid === 1'b1) begin
        pcs[got] = id_pc;
        got++;
      end
      step(1'b1, 1'b0, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= got || pcs[i] !== 32'hFFFF_FFFC + 32'(4 * i)) begin
        tests_failed++;
        $display("FAIL wrap_order_%0d: got %h expected %h", i, (i < got) ? pcs[i] : 32'hx,
                 32'hFFFF_FFFC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_perf();
    int   guard;
    logic done_redir;
    resp_lat = 2;
    do_reset(2);
    guard = 0;
    done_redir = 1'b0;
    while (n_resp < 10 && guard < 300) begin
      if (!done_redir && n_resp == 4 && inst_read === 1'b1 && wait_cnt == 0) begin
        step(1'b1, 1'b1, 32'h300);
        done_redir = 1'b1;
      end else begin
        step(1'b1, 1'b0, 32'h0);
      end
      guard++;
    end
    if (guard >= 300) begin
      tests_run++;
      tests_failed++;
      $display("FAIL perf_timeout: got %0d responses expected 10", n_resp);
    end
`ifdef FETCH_PERF_EN
    tests_run += 3;
    if (perf_fetched !== 32'd9) begin tests_failed++; $display("FAIL perf_fetched: got %0d expected 9", perf_fetched); end
    if (perf_stall !== 32'd20) begin tests_failed++; $display("FAIL perf_stall: got %0d expected 20", perf_stall); end
    if (perf_flush !== 32'd1) begin tests_failed++; $display("FAIL perf_flush: got %0d expected 1", perf_flush); end
`endif
    repeat (4) step(1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    rst            = 1'b0;
    inst_resp      = 1'b0;
    inst_rdata     = 32'h0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    id_ready       = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_redirect_resp();
    test_reset_mid();
    test_wrap();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
